// File: rtl/fifo_word_packer.sv
// Packs consecutive FIFO entries into little-endian words with a byte-keep mask;
// a flush pulse emits any partial word marked with out_last.
module fifo_word_packer #(
  parameter int FIFO_WIDTH = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                             read_clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  output logic                             fifo_read_en,
  input  logic [FIFO_WIDTH-1:0]            fifo_read_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [FIFO_WIDTH*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]            out_keep,
  output logic                             out_last
);
  localparam int OW = FIFO_WIDTH * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WORD_BYTES);

  typedef enum logic {ST_FILL, ST_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [OW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       acc_cnt_q, acc_cnt_d;
  logic                inflight_q;
  logic                out_valid_q, out_valid_d;
  logic [OW-1:0]       out_data_q, out_data_d;
  logic [WORD_BYTES-1:0] out_keep_q, out_keep_d;
  logic                out_last_q, out_last_d;
  logic                out_free, xfer, flush_load, load, rd_en;
  logic [CW:0]         pending;

  function automatic logic [WORD_BYTES-1:0] keep_mask(input logic [CW-1:0] cnt);
    logic [WORD_BYTES-1:0] m;
    for (int i = 0; i < WORD_BYTES; i++) m[i] = (CW'(i) < cnt);
    return m;
  endfunction

  function automatic logic [OW-1:0] mask_lanes(input logic [OW-1:0] acc,
                                                input logic [WORD_BYTES-1:0] keep);
    logic [OW-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      if (keep[i]) r[i*FIFO_WIDTH +: FIFO_WIDTH] = acc[i*FIFO_WIDTH +: FIFO_WIDTH];
    return r;
  endfunction

  // Bytes already owned by the accumulator, counting the one still in flight
  assign pending    = {1'b0, acc_cnt_q} + {{CW{1'b0}}, inflight_q};
  assign out_free   = !out_valid_q || out_ready;
  assign xfer       = (state_q == ST_FILL) && (acc_cnt_q == FULL_CNT) && out_free;
  assign flush_load = (state_q == ST_FLUSH) && !inflight_q && (acc_cnt_q != '0) && out_free;
  assign load       = xfer || flush_load;
  assign rd_en      = rst && !fifo_empty && (state_q == ST_FILL) &&
                      ((pending < {1'b0, FULL_CNT}) || xfer);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    acc_cnt_d   = acc_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mask_lanes(acc_q, keep_mask(acc_cnt_q));
      out_keep_d  = keep_mask(acc_cnt_q);
      out_last_d  = flush_load;
      acc_cnt_d   = '0;
    end

    // A loaded word frees lane 0 for the byte landing on the same edge
    if (inflight_q) begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (CW'(i) == acc_cnt_d) acc_d[i*FIFO_WIDTH +: FIFO_WIDTH] = fifo_read_data;
      acc_cnt_d = acc_cnt_d + CW'(1);
    end

    if (state_q == ST_FILL) begin
      if (flush) state_d = ST_FLUSH;
    end else if (!inflight_q && ((acc_cnt_q == '0) || out_free)) begin
      state_d = ST_FILL;
    end
  end

  always_ff @(posedge read_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      acc_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      inflight_q  <= rd_en;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  // Lane contents are only meaningful below acc_cnt, so they need no reset
  always_ff @(posedge read_clk) begin
    acc_q <= acc_d;
  end

  assign fifo_read_en = rd_en;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_keep     = out_keep_q;
  assign out_last     = out_last_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a queue-based FIFO model feeds the DUT and
// a byte-stream reference model predicts every output word.
module tb_fifo_word_packer;
  localparam int FW = 8;
  localparam int WB = 4;
  localparam int OW = FW * WB;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [WB-1:0] keep;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_en;
  logic [FW-1:0] fifo_read_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic [WB-1:0] out_keep;
  logic          out_last;

  word_t         sb[$];
  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] pend[$];
  int            rise_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            first_pop = -1;
  int            empty_viol = 0;

  fifo_word_packer #(.FIFO_WIDTH(FW), .WORD_BYTES(WB)) dut (
    .read_clk       (clk),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_read_en   (fifo_read_en),
    .fifo_read_data (fifo_read_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_keep       (out_keep),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: bytes chunk into words of WB; a flush emits the remainder.
  function automatic void emit(input logic last);
    word_t w;
    w = '0;
    for (int i = 0; i < pend.size(); i++) begin
      w.data[i*FW +: FW] = pend[i];
      w.keep[i] = 1'b1;
    end
    w.last = last;
    sb.push_back(w);
    pend.delete();
  endfunction

  function automatic void model_byte(input logic [FW-1:0] b, input bit chunk);
    pend.push_back(b);
    if (chunk && pend.size() == WB) emit(1'b0);
  endfunction

  function automatic void model_flush();
    if (pend.size() != 0) emit(1'b1);
  endfunction

  // mode 0: FIFO only, 1: model with chunking, 2: model without chunking
  task automatic push_byte(input logic [FW-1:0] b, input int mode);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    if (mode == 1) model_byte(b, 1'b1);
    else if (mode == 2) model_byte(b, 1'b0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((fifo_q.size() != 0 || sb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Upstream FIFO: read data appears the cycle after a pop
  always begin : fifo_model
    logic [FW-1:0] v;
    bit            popped;
    @(posedge clk);
    cyc++;
    popped = 1'b0;
    v = '0;
    if (rst && fifo_read_en) begin
      if (first_pop < 0) first_pop = cyc;
      if (fifo_q.size() == 0) empty_viol++;
      else begin
        v = fifo_q.pop_front();
        popped = 1'b1;
      end
    end
    #1;
    if (popped) fifo_read_data = v;
    fifo_empty = (fifo_q.size() == 0);
  end

  always begin : empty_watch
    @(negedge clk);
    #2;
    if (rst && fifo_read_en && fifo_empty) empty_viol++;
  end

  always begin : monitor
    word_t held;
    word_t exp_w;
    bit    hold;
    bit    prev_v;
    @(negedge clk);
    #3;
    if (!rst) begin
      hold = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (hold) begin
        total++;
        if ({out_valid, out_data, out_keep, out_last} !== {1'b1, held}) begin
          bad++;
          $display("FAIL hold_stable: got v=%0b data=0x%0h keep=0x%0h last=%0b expected v=1 data=0x%0h keep=0x%0h last=%0b",
                   out_valid, out_data, out_keep, out_last, held.data, held.keep, held.last);
        end
      end
      if (out_valid && !prev_v) rise_q.push_back(cyc);
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got data=0x%0h keep=0x%0h last=%0b expected no word",
                   out_data, out_keep, out_last);
        end else begin
          exp_w = sb.pop_front();
          if ({out_data, out_keep, out_last} !== exp_w) begin
            bad++;
            $display("FAIL word: got data=0x%0h keep=0x%0h last=%0b expected data=0x%0h keep=0x%0h last=%0b",
                     out_data, out_keep, out_last, exp_w.data, exp_w.keep, exp_w.last);
          end
        end
      end
      hold = out_valid && !out_ready;
      held = {out_data, out_keep, out_last};
      prev_v = out_valid;
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_read_en", 64'(fifo_read_en), 64'd0);
    check("reset_valid",   64'(out_valid),    64'd0);
    check("reset_data",    64'(out_data),     64'd0);
    check("reset_keep",    64'(out_keep),     64'd0);
    check("reset_last",    64'(out_last),     64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;

    // Two full words, latency and word interval
    first_pop = -1;
    rise_q.delete();
    @(negedge clk);
    for (int i = 0; i < 8; i++) push_byte(8'(i), 1);
    drain();
    if (first_pop < 0 || rise_q.size() < 2) begin
      total++;
      bad++;
      $display("FAIL latency: got %0d valid rises expected 2", rise_q.size());
    end else begin
      check("latency",       64'(rise_q[0] - first_pop), 64'd5);
      check("word_interval", 64'(rise_q[1] - rise_q[0]), 64'd5);
    end

    // Partial word via flush after the FIFO runs empty
    @(negedge clk);
    push_byte(8'hA1, 1);
    push_byte(8'hA2, 1);
    push_byte(8'hA3, 1);
    drain();
    do_flush();
    drain();

    // Backpressure: one word held, accumulator full, reads stop
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_byte(8'(8'h10 + i), 1);
    repeat (20) @(negedge clk);
    #1;
    check("reads_stop",  64'(fifo_q.size()), 64'd4);
    check("held_valid",  64'(out_valid),     64'd1);
    check("held_data",   64'(out_data),      64'h13121110);
    check("held_keep",   64'(out_keep),      64'hF);
    check("held_last",   64'(out_last),      64'd0);
    drain();

    // Flush with nothing accumulated
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push_byte(8'h55, 1);
    #1;
    check("flush_blocks_read", 64'(fifo_read_en), 64'd0);
    @(negedge clk);
    #1;
    check("fill_after_empty_flush", 64'(fifo_read_en), 64'd1);
    drain();
    do_flush();
    drain();

    // Flush coinciding with the pop of the 4th byte
    @(negedge clk);
    push_byte(8'hC1, 1);
    push_byte(8'hC2, 1);
    push_byte(8'hC3, 1);
    drain();
    @(negedge clk);
    push_byte(8'hC4, 2);
    flush = 1'b1;
    model_flush();
    #1;
    check("pop_with_flush", 64'(fifo_read_en), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    drain();

    // Reset with two bytes accumulated and one in flight
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_byte(8'(8'hD0 + i), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_read_en", 64'(fifo_read_en), 64'd0);
    check("rst_valid",   64'(out_valid),    64'd0);
    check("rst_data",    64'(out_data),     64'd0);
    check("rst_keep",    64'(out_keep),     64'd0);
    check("rst_last",    64'(out_last),     64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("first_pop_after_release", 64'(fifo_read_en), 64'd1);
    model_byte(8'hD3, 1'b1);
    push_byte(8'hE1, 1);
    push_byte(8'hE2, 1);
    push_byte(8'hE3, 1);
    drain();

    // Randomized traffic with random backpressure and occasional flushes
    for (int r = 0; r < 8; r++) begin
      repeat (40) begin
        @(negedge clk);
        if ($urandom_range(0, 2) != 0) push_byte(8'($urandom_range(0, 255)), 1);
        out_ready = ($urandom_range(0, 3) != 0);
      end
      drain();
      if ($urandom_range(0, 1) == 1) begin
        do_flush();
        drain();
      end
    end
    do_flush();
    drain();

    check("no_read_while_empty", 64'(empty_viol), 64'd0);
    check("scoreboard_empty",    64'(sb.size()),  64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
